// File: rtl/lsq_pkg.sv
// Shared types for the load/store memory client: per-entry lifecycle state
// and the read/write encoding used on the request port.
package lsq_pkg;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } entry_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/lsq_entry_ram.sv
// Per-entry payload storage: tag written at allocation (port A), load data
// written when the response arrives (port B), asynchronous read at the head.
module lsq_entry_ram #(
  parameter int ID_BITS    = 4,
  parameter int LINE_WIDTH = 32,
  parameter int TAG_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic [ID_BITS-1:0]    a_addr,
  input  logic [TAG_BITS-1:0]   a_tag,
  input  logic                  b_en,
  input  logic [ID_BITS-1:0]    b_addr,
  input  logic [LINE_WIDTH-1:0] b_data,
  input  logic [ID_BITS-1:0]    rd_addr,
  output logic [LINE_WIDTH-1:0] rd_data,
  output logic [TAG_BITS-1:0]   rd_tag
);

  localparam int DEPTH = 1 << ID_BITS;

  logic [LINE_WIDTH-1:0] data_mem [DEPTH];
  logic [TAG_BITS-1:0]   tag_mem  [DEPTH];

  // The two ports own disjoint fields, so they never collide even on the same entry.
  always_ff @(posedge clk) begin
    if (a_en) tag_mem[a_addr] <= a_tag;
  end

  always_ff @(posedge clk) begin
    if (b_en) data_mem[b_addr] <= b_data;
  end

  assign rd_data = data_mem[rd_addr];
  assign rd_tag  = tag_mem[rd_addr];

endmodule

// File: rtl/lsq_mem_client.sv
// Core-side ld/st memory initiator: tags loads with a queue id, collects
// out-of-order responses, retires load results in program order.
// Optional watchdog on the head entry is enabled with LSQ_TIMEOUT_EN.
module lsq_mem_client
  import lsq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 32,
  parameter int CREG_ID_BITS   = 4,
  parameter int TAG_BITS       = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_valid,
  input  logic                    core_rw,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  input  logic [LINE_WIDTH-1:0]   core_data,
  input  logic [TAG_BITS-1:0]     core_tag,
  output logic                    core_ready,
  output logic                    ld_valid,
  output logic [LINE_WIDTH-1:0]   ld_data,
  output logic [TAG_BITS-1:0]     ld_tag,
  output logic                    mem_valid_out,
  output logic                    mem_rw_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [LINE_WIDTH-1:0]   mem_data_out,
  output logic [CREG_ID_BITS-1:0] mem_id_out,
  input  logic [LINE_WIDTH-1:0]   mem_data_in,
  input  logic [CREG_ID_BITS-1:0] mem_id_in,
  input  logic                    mem_ready_in,
  input  logic                    mem_stall_in,
  output logic                    lsq_empty,
  output logic                    timeout_err,
  output logic [1:0]              head_state
);

  localparam int DEPTH = 1 << CREG_ID_BITS;

  // Handshake: a request transfers on a rising clk edge where core_valid and
  // core_ready are both 1; core_valid must not depend on core_ready.
  logic [CREG_ID_BITS-1:0] head, tail;
  logic [CREG_ID_BITS:0]   count;
  entry_state_t            state [DEPTH];

  logic                  accept, alloc, retire, resp_ok;
  logic [LINE_WIDTH-1:0] head_data;
  logic [TAG_BITS-1:0]   head_tag;

  // count has one extra bit, so its MSB alone marks a full queue.
  assign core_ready = reset & !(mem_valid_out & mem_stall_in)
                      & ((core_rw == RW_WRITE) | !count[CREG_ID_BITS]);
  assign accept     = core_valid & core_ready;
  assign alloc      = accept & (core_rw == RW_READ);
  assign retire     = (state[head] == ST_DONE);
  assign resp_ok    = mem_ready_in & (state[mem_id_in] == ST_PEND);
  assign lsq_empty  = (count == '0) & !mem_valid_out;
  assign head_state = state[head];

  lsq_entry_ram #(
    .ID_BITS    (CREG_ID_BITS),
    .LINE_WIDTH (LINE_WIDTH),
    .TAG_BITS   (TAG_BITS)
  ) u_ram (
    .clk     (clk),
    .a_en    (alloc),
    .a_addr  (tail),
    .a_tag   (core_tag),
    .b_en    (resp_ok),
    .b_addr  (mem_id_in),
    .b_data  (mem_data_in),
    .rd_addr (head),
    .rd_data (head_data),
    .rd_tag  (head_tag)
  );

  // Issue stage: one registered request, frozen while memory stalls it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid_out <= 1'b0;
      mem_rw_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_data_out  <= '0;
      mem_id_out    <= '0;
    end else if (accept) begin
      mem_valid_out <= 1'b1;
      mem_rw_out    <= core_rw;
      mem_addr_out  <= core_addr;
      mem_data_out  <= core_data;
      mem_id_out    <= (core_rw == RW_WRITE) ? '0 : tail;
    end else if (!mem_stall_in) begin
      mem_valid_out <= 1'b0;
    end
  end

  // Entry lifecycle. Alloc hits a FREE entry, a response a PEND one and
  // retire a DONE one, so same-cycle updates always target distinct entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ld_valid <= 1'b0;
      ld_data  <= '0;
      ld_tag   <= '0;
      for (int i = 0; i < DEPTH; i++) state[i] <= ST_FREE;
    end else begin
      ld_valid <= retire;
      if (retire) begin
        ld_data     <= head_data;
        ld_tag      <= head_tag;
        state[head] <= ST_FREE;
        head        <= head + 1'b1;
      end
      if (resp_ok) state[mem_id_in] <= ST_DONE;
      if (alloc) begin
        state[tail] <= ST_PEND;
        tail        <= tail + 1'b1;
      end
      case ({alloc, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset && mem_ready_in)
      assert (state[mem_id_in] == ST_PEND)
      else $error("lsq_mem_client: response for non-pending id %0d", mem_id_in);
  end

`ifdef LSQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      if (retire)
        wd_cnt <= '0;
      else if (state[head] == ST_PEND && wd_cnt != TW'(TIMEOUT_CYCLES))
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == TW'(TIMEOUT_CYCLES)) wd_err <= 1'b1;
    end
  end

  assign timeout_err = wd_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsq_mem_client.sv
// Directed bench for lsq_mem_client with a behavioural memory and an
// in-order load-result scoreboard.
module tb_lsq_mem_client;

  localparam int AW  = 32;
  localparam int LW  = 32;
  localparam int IDB = 4;
  localparam int TGB = 5;
  localparam int W   = LW + TGB;
  localparam int IW  = 1 + IDB + AW + LW;

  logic           clk, reset;
  logic           core_valid, core_rw, core_ready;
  logic [AW-1:0]  core_addr;
  logic [LW-1:0]  core_data;
  logic [TGB-1:0] core_tag;
  logic           ld_valid;
  logic [LW-1:0]  ld_data;
  logic [TGB-1:0] ld_tag;
  logic           mem_valid_out, mem_rw_out;
  logic [AW-1:0]  mem_addr_out;
  logic [LW-1:0]  mem_data_out;
  logic [IDB-1:0] mem_id_out;
  logic [LW-1:0]  mem_data_in;
  logic [IDB-1:0] mem_id_in;
  logic           mem_ready_in, mem_stall_in;
  logic           lsq_empty, timeout_err;
  logic [1:0]     head_state;

  lsq_mem_client dut (
    .clk(clk), .reset(reset),
    .core_valid(core_valid), .core_rw(core_rw), .core_addr(core_addr),
    .core_data(core_data), .core_tag(core_tag), .core_ready(core_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_tag(ld_tag),
    .mem_valid_out(mem_valid_out), .mem_rw_out(mem_rw_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .mem_id_out(mem_id_out), .mem_data_in(mem_data_in), .mem_id_in(mem_id_in),
    .mem_ready_in(mem_ready_in), .mem_stall_in(mem_stall_in),
    .lsq_empty(lsq_empty), .timeout_err(timeout_err), .head_state(head_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [W-1:0]  exp_q [$];
  logic [IW-1:0] iss_q [$];
  int            ld_cyc_q [$];

  logic          pend  [16];
  int            due   [16];
  logic [LW-1:0] rdata [16];
  bit            auto_resp;
  int            lat;
  int            n_issue = 0;
  int            ld_count = 0;
  int            last_acc = 0;
  logic [IDB-1:0] tb_tail;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", name, obs, exp);
  endtask

  function automatic logic [LW-1:0] memfn(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic flush_model();
    exp_q.delete();
    iss_q.delete();
    for (int i = 0; i < 16; i++) pend[i] = 1'b0;
    tb_tail = '0;
    mem_ready_in = 1'b0;
    mem_id_in = '0;
    mem_data_in = '0;
  endtask

  // driver tasks; inputs change only at the falling edge
  task automatic offer(input logic rw, input logic [AW-1:0] a,
                       input logic [LW-1:0] d, input logic [TGB-1:0] t);
    core_valid = 1'b1; core_rw = rw; core_addr = a; core_data = d; core_tag = t;
    #1;
  endtask

  task automatic idle();
    core_valid = 1'b0; core_rw = 1'b0;
    #1;
  endtask

  // One clock: memory model and handshake bookkeeping before the edge,
  // scoreboard check on load results at the following falling edge.
  task automatic cycle();
    logic          hit;
    logic [IW-1:0] e;
    logic [W-1:0]  x;
    hit = 1'b0;
    mem_ready_in = 1'b0; mem_id_in = '0; mem_data_in = '0;
    for (int i = 0; i < 16; i++) begin
      if (!hit && pend[i] && due[i] <= cyc + 1) begin
        hit = 1'b1;
        pend[i] = 1'b0;
        mem_ready_in = 1'b1;
        mem_id_in = IDB'(i);
        mem_data_in = rdata[i];
      end
    end
    if (core_valid && core_ready) begin
      iss_q.push_back({core_rw, (core_rw ? 4'd0 : tb_tail), core_addr, core_data});
      if (!core_rw) begin
        exp_q.push_back({core_tag, memfn(core_addr)});
        tb_tail++;
      end
      last_acc = cyc + 1;
    end
    if (mem_valid_out && !mem_stall_in) begin
      n_issue++;
      if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
      else begin
        e = iss_q.pop_front();
        chk("issue_rw", mem_rw_out, e[IW-1]);
        chk("issue_id", mem_id_out, e[AW+LW +: IDB]);
        chk("issue_addr", mem_addr_out, e[LW +: AW]);
        if (e[IW-1]) chk("issue_data", mem_data_out, e[LW-1:0]);
      end
      if (!mem_rw_out) begin
        pend[mem_id_out]  = 1'b1;
        due[mem_id_out]   = auto_resp ? cyc + 1 + lat : 32'h7fff_ffff;
        rdata[mem_id_out] = memfn(mem_addr_out);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (ld_valid) begin
      ld_count++;
      ld_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("ld_unexpected", 1, 0);
      else begin
        x = exp_q.pop_front();
        chk("ld_data", ld_data, x[LW-1:0]);
        chk("ld_tag", ld_tag, x[W-1:LW]);
      end
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int c0, acc, n, base, i0, lat_obs;
    reset = 1'b0;
    core_valid = 1'b0; core_rw = 1'b0; core_addr = '0; core_data = '0; core_tag = '0;
    mem_stall_in = 1'b0;
    auto_resp = 1'b1;
    lat = 128;
    flush_model();

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_core_ready", core_ready, 0);
    chk("rst_mem_valid", mem_valid_out, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_lsq_empty", lsq_empty, 1);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_head_state", head_state, 0);
    reset = 1'b1;
    cycle();
    chk("post_rst_ready", core_ready, 1);

    // single load, 128-cycle memory
    c0 = ld_count;
    offer(1'b0, 32'h40, 32'h0, 5'd5);
    cycle();
    idle();
    acc = last_acc;
    chk("t1_not_empty", lsq_empty, 0);
    n = 0;
    while (ld_count == c0 && n < 300) begin cycle(); n++; end
    chk("t1_seen", ld_count, c0 + 1);
    lat_obs = (ld_cyc_q.size() > 0) ? ld_cyc_q[$] - acc : -1;
    chk("t1_latency", lat_obs, 130);
    chk("t1_empty_after", lsq_empty, 1);

    // fill all 16 entries; 17th load refused, store in that cycle accepted
    lat = 40;
    for (int i = 0; i < 16; i++) begin
      offer(1'b0, AW'($urandom_range(32'h0, 32'hFFFF)) << 2, $urandom, TGB'(i + 1));
      chk("fill_ready", core_ready, 1);
      cycle();
    end
    offer(1'b0, 32'h1000, 32'h0, 5'd30);
    chk("full_load_ready", core_ready, 0);
    offer(1'b1, 32'h2000, 32'hCAFE_F00D, 5'd0);
    chk("full_store_ready", core_ready, 1);
    cycle();
    idle();
    wait_drain(300, "fill_drain");
    cycle();
    chk("fill_iss_empty", iss_q.size(), 0);
    chk("fill_lsq_empty", lsq_empty, 1);

    // responses 3,1,2 -> results for 1,2,3 on consecutive cycles
    auto_resp = 1'b0;
    offer(1'b0, 32'h300, 32'h0, 5'd21); cycle();
    offer(1'b0, 32'h304, 32'h0, 5'd22); cycle();
    offer(1'b0, 32'h308, 32'h0, 5'd23); cycle();
    idle();
    repeat (3) cycle();
    ld_cyc_q.delete();
    base = cyc;
    due[3] = base + 1;
    due[1] = base + 2;
    due[2] = base + 3;
    n = 0;
    while (ld_cyc_q.size() < 3 && n < 30) begin cycle(); n++; end
    chk("ooo_count", ld_cyc_q.size(), 3);
    if (ld_cyc_q.size() >= 3) begin
      chk("ooo_cyc0", ld_cyc_q[0], base + 3);
      chk("ooo_cyc1", ld_cyc_q[1], base + 4);
      chk("ooo_cyc2", ld_cyc_q[2], base + 5);
    end
    auto_resp = 1'b1;

    // memory stall holds the issue register for 5 cycles
    lat = 10;
    offer(1'b1, 32'hC0, 32'hDEAD_BEEF, 5'd0);
    cycle();
    mem_stall_in = 1'b1;
    offer(1'b1, 32'h100, 32'h1234, 5'd0);
    i0 = n_issue;
    repeat (5) begin
      chk("stall_core_ready", core_ready, 0);
      cycle();
      chk("stall_valid", mem_valid_out, 1);
      chk("stall_rw", mem_rw_out, 1);
      chk("stall_addr", mem_addr_out, 32'hC0);
      chk("stall_data", mem_data_out, 32'hDEAD_BEEF);
    end
    idle();
    mem_stall_in = 1'b0;
    #1;
    chk("unstall_ready", core_ready, 1);
    cycle();
    cycle();
    chk("stall_issued_once", n_issue - i0, 1);
    chk("stall_valid_drop", mem_valid_out, 0);

    // reset with 8 loads in flight
    lat = 100;
    for (int i = 0; i < 8; i++) begin
      offer(1'b0, 32'h800 + AW'(i * 4), 32'h0, TGB'(i));
      cycle();
    end
    idle();
    repeat (30) cycle();
    reset = 1'b0;
    #1;
    flush_model();
    c0 = ld_count;
    chk("mid_rst_valid", mem_valid_out, 0);
    chk("mid_rst_rw", mem_rw_out, 0);
    chk("mid_rst_addr", mem_addr_out, 0);
    chk("mid_rst_data", mem_data_out, 0);
    chk("mid_rst_id", mem_id_out, 0);
    chk("mid_rst_ld", ld_valid, 0);
    chk("mid_rst_ready", core_ready, 0);
    chk("mid_rst_empty", lsq_empty, 1);
    repeat (2) cycle();
    reset = 1'b1;
    repeat (150) cycle();
    chk("mid_rst_no_ld", ld_count, c0);
    chk("mid_rst_empty2", lsq_empty, 1);

    // fresh load after reset starts again at id 0
    offer(1'b0, 32'h200, 32'h0, 5'd9);
    cycle();
    idle();
    wait_drain(200, "post_rst_drain");

`ifdef LSQ_TIMEOUT_EN
    auto_resp = 1'b0;
    offer(1'b0, 32'h500, 32'h0, 5'd17);
    cycle();
    idle();
    repeat (300) cycle();
    chk("timeout_set", timeout_err, 1);
    due[tb_tail - 1'b1] = cyc + 1;
    auto_resp = 1'b1;
    wait_drain(50, "timeout_drain");
    repeat (5) cycle();
    chk("timeout_sticky", timeout_err, 1);
`else
    chk("timeout_tied", timeout_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
